// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared types and constants for the instruction queue
// Purpose: default geometry, exception cause codes and the packed entry layout
//          used by inst_queue and inst_queue_ram.
// Ports:   none (package).
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int IQ_PTR_W = 3;

    // 7-bit fetch exception cause codes
    localparam logic [6:0] EXCEPTION_NOP  = 7'h00;
    localparam logic [6:0] EXCEPTION_ADEF = 7'h08;

    // pc + inst + excp + cause
    localparam int IQ_ENTRY_W = 32 + 32 + 1 + 7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - DEPTH x IQ_ENTRY_W register array, 2 write / 2 async read
// Purpose: entry storage for inst_queue. Storage is deliberately not reset.
// Ports:
//   clk              clock
//   we1/we2          write enables for write ports 1/2
//   waddr1/waddr2    write addresses (tail, tail+1)
//   wdata1/wdata2    packed entries to write
//   raddr1/raddr2    read addresses (head, head+1)
//   rdata1/rdata2    combinational read data
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = IQ_PTR_W
) (
    input  logic                  clk,
    input  logic                  we1,
    input  logic [PTR_W-1:0]      waddr1,
    input  logic [IQ_ENTRY_W-1:0] wdata1,
    input  logic                  we2,
    input  logic [PTR_W-1:0]      waddr2,
    input  logic [IQ_ENTRY_W-1:0] wdata2,
    input  logic [PTR_W-1:0]      raddr1,
    input  logic [PTR_W-1:0]      raddr2,
    output logic [IQ_ENTRY_W-1:0] rdata1,
    output logic [IQ_ENTRY_W-1:0] rdata2
);

    logic [IQ_ENTRY_W-1:0] r_mem [DEPTH];

    // The controller always drives distinct addresses when both ports write.
    always_ff @(posedge clk) begin
        if (we1) r_mem[waddr1] <= wdata1;
        if (we2) r_mem[waddr2] <= wdata2;
    end

    assign rdata1 = r_mem[raddr1];
    assign rdata2 = r_mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-push / dual-pop instruction buffer between fetch and decode
// Purpose: queues up to two fetched instructions per cycle (pc, inst, exception info),
//          presents the two oldest to decode in order, requests fetch pause early
//          enough for in-flight pairs to still fit, and empties on flush.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush                          backend redirect, empties the queue
//   push_valid1/2                  fetch slot valids (slot 2 needs slot 1)
//   push_pc1/2, push_inst1/2       fetched pc / instruction word
//   push_excp1/2, push_cause1/2    fetch exception flag / cause
//   dec_ready1/2                   decode accepts output slot 1/2
//   out_valid1/2 .. out_cause1/2   head / head+1 entry
//   pause_req                      pause request to the pc generator
//   count                          current occupancy
//   ovf_err                        one-cycle pulse: a push pair was dropped
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = IQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid1,
    input  logic             push_valid2,
    input  logic [31:0]      push_pc1,
    input  logic [31:0]      push_pc2,
    input  logic [31:0]      push_inst1,
    input  logic [31:0]      push_inst2,
    input  logic             push_excp1,
    input  logic             push_excp2,
    input  logic [6:0]       push_cause1,
    input  logic [6:0]       push_cause2,
    input  logic             dec_ready1,
    input  logic             dec_ready2,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_pc2,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_inst2,
    output logic             out_excp1,
    output logic             out_excp2,
    output logic [6:0]       out_cause1,
    output logic [6:0]       out_cause2,
    output logic             pause_req,
    output logic [PTR_W:0]   count,
    output logic             ovf_err
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [CNT_W-1:0] w_free;
    logic [1:0]       w_npush;
    logic             w_fits;
    logic             w_push_ok;
    logic             w_drop;
    logic [1:0]       w_nacc;
    logic             w_pop1;
    logic             w_pop2;
    logic [1:0]       w_npop;
    logic             w_we1;
    logic             w_we2;

    logic [IQ_ENTRY_W-1:0] w_wdata1;
    logic [IQ_ENTRY_W-1:0] w_wdata2;
    logic [IQ_ENTRY_W-1:0] w_rdata1;
    logic [IQ_ENTRY_W-1:0] w_rdata2;
    iq_entry_t             w_rd1;
    iq_entry_t             w_rd2;

    // Free space comes from the registered count, so a pop in the same cycle
    // does not make room for this cycle's push.
    assign w_free    = DEPTH_C - r_count;
    assign w_npush   = {1'b0, push_valid1} + {1'b0, push_valid1 & push_valid2};
    assign w_fits    = {{(CNT_W-2){1'b0}}, w_npush} <= w_free;
    // A pair that does not fully fit is dropped whole; flush suppresses both.
    assign w_push_ok = !flush && w_fits;
    assign w_drop    = !flush && !w_fits;
    assign w_nacc    = w_push_ok ? w_npush : 2'd0;
    assign w_we1     = w_push_ok && push_valid1;
    assign w_we2     = w_push_ok && push_valid1 && push_valid2;

    assign out_valid1 = (r_count != '0);
    assign out_valid2 = (r_count >= CNT_W'(2));

    // Slot 2 only leaves together with slot 1 to keep program order.
    assign w_pop1 = out_valid1 && dec_ready1;
    assign w_pop2 = w_pop1 && out_valid2 && dec_ready2;
    assign w_npop = {1'b0, w_pop1} + {1'b0, w_pop2};

    // Margin of 4: one pair already in flight plus one issued while pausing.
    assign pause_req = (w_free < CNT_W'(4));
    assign count     = r_count;
    assign ovf_err   = r_ovf;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_npop);
            r_tail  <= r_tail + PTR_W'(w_nacc);
            r_count <= r_count + CNT_W'(w_nacc) - CNT_W'(w_npop);
            r_ovf   <= w_drop;
        end
    end

    assign w_wdata1 = {push_pc1, push_inst1, push_excp1, push_cause1};
    assign w_wdata2 = {push_pc2, push_inst2, push_excp2, push_cause2};

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we1    (w_we1),
        .waddr1 (r_tail),
        .wdata1 (w_wdata1),
        .we2    (w_we2),
        .waddr2 (r_tail + PTR_W'(1)),
        .wdata2 (w_wdata2),
        .raddr1 (r_head),
        .raddr2 (r_head + PTR_W'(1)),
        .rdata1 (w_rdata1),
        .rdata2 (w_rdata2)
    );

    assign w_rd1 = iq_entry_t'(w_rdata1);
    assign w_rd2 = iq_entry_t'(w_rdata2);

    assign out_pc1    = w_rd1.pc;
    assign out_inst1  = w_rd1.inst;
    assign out_excp1  = w_rd1.excp;
    assign out_cause1 = w_rd1.cause;
    assign out_pc2    = w_rd2.pc;
    assign out_inst2  = w_rd2.inst;
    assign out_excp2  = w_rd2.excp;
    assign out_cause2 = w_rd2.cause;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue (DEPTH=8)
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push_valid1, push_valid2;
    logic [31:0] push_pc1, push_pc2, push_inst1, push_inst2;
    logic        push_excp1, push_excp2;
    logic [6:0]  push_cause1, push_cause2;
    logic        dec_ready1, dec_ready2;
    logic        out_valid1, out_valid2;
    logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
    logic        out_excp1, out_excp2;
    logic [6:0]  out_cause1, out_cause2;
    logic        pause_req;
    logic [3:0]  count;
    logic        ovf_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid1(push_valid1), .push_valid2(push_valid2),
        .push_pc1(push_pc1), .push_pc2(push_pc2),
        .push_inst1(push_inst1), .push_inst2(push_inst2),
        .push_excp1(push_excp1), .push_excp2(push_excp2),
        .push_cause1(push_cause1), .push_cause2(push_cause2),
        .dec_ready1(dec_ready1), .dec_ready2(dec_ready2),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_excp1(out_excp1), .out_excp2(out_excp2),
        .out_cause1(out_cause1), .out_cause2(out_cause2),
        .pause_req(pause_req), .count(count), .ovf_err(ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a push of nv entries (0,1,2) starting at pc, plus the decode readies.
    task automatic drive(input int nv, input logic [31:0] pc, input logic r1, input logic r2);
        push_valid1 = (nv >= 1);
        push_valid2 = (nv >= 2);
        push_pc1    = pc;
        push_pc2    = pc + 32'd4;
        push_inst1  = ~pc;
        push_inst2  = ~(pc + 32'd4);
        push_excp1  = 1'b0;
        push_excp2  = 1'b0;
        push_cause1 = EXCEPTION_NOP;
        push_cause2 = EXCEPTION_NOP;
        dec_ready1  = r1;
        dec_ready2  = r2;
    endtask

    initial begin
        int          mcount;
        int          sent;
        int          popped;
        int          cyc;
        logic [31:0] exp_pc;
        logic        r1, r2, pv, p1, p2;

        rst = 1'b1;
        flush = 1'b0;
        drive(0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_valid1", out_valid1, 0);
        chk("rst_valid2", out_valid2, 0);
        chk("rst_pause", pause_req, 0);
        chk("rst_ovf", ovf_err, 0);

        // first pair, no pops
        drive(2, 32'h1c000000, 1'b0, 1'b0);
        step();
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t1_valid1", out_valid1, 1);
        chk("t1_valid2", out_valid2, 1);
        chk("t1_pc1", out_pc1, 32'h1c000000);
        chk("t1_pc2", out_pc2, 32'h1c000004);
        chk("t1_inst1", out_inst1, ~32'h1c000000);
        chk("t1_count", count, 2);

        // fill up to full, then overflow
        drive(2, 32'h1c000008, 1'b0, 1'b0);
        step();
        chk("t2_count4", count, 4);
        chk("t2_pause4", pause_req, 0);
        drive(2, 32'h1c000010, 1'b0, 1'b0);
        step();
        chk("t2_count6", count, 6);
        chk("t2_pause6", pause_req, 1);
        drive(2, 32'h1c000018, 1'b0, 1'b0);
        step();
        chk("t2_count8", count, 8);
        chk("t2_ovf_full", ovf_err, 0);
        chk("t2_head_pc", out_pc1, 32'h1c000000);
        drive(2, 32'h1c000020, 1'b0, 1'b0);
        step();
        chk("t2_drop_ovf", ovf_err, 1);
        chk("t2_drop_count", count, 8);
        drive(0, 32'h0, 1'b1, 1'b0);
        step();
        chk("t2_ovf_pulse", ovf_err, 0);
        chk("t2_pop1_count", count, 7);
        chk("t2_pop1_pc", out_pc1, 32'h1c000004);
        // pair into one free slot is dropped whole
        drive(2, 32'h1c000020, 1'b0, 1'b0);
        step();
        chk("t2_pair_drop_ovf", ovf_err, 1);
        chk("t2_pair_drop_count", count, 7);
        drive(1, 32'h1c000020, 1'b0, 1'b0);
        step();
        chk("t2_single_fit_count", count, 8);
        chk("t2_single_fit_ovf", ovf_err, 0);
        // flush while full and pushing: no overflow, queue empties
        flush = 1'b1;
        drive(2, 32'h1c000024, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t2_flush_count", count, 0);
        chk("t2_flush_ovf", ovf_err, 0);
        chk("t2_flush_valid1", out_valid1, 0);
        chk("t2_flush_pause", pause_req, 0);

        // partial pops
        drive(2, 32'h1c000100, 1'b0, 1'b0);
        step();
        drive(1, 32'h1c000108, 1'b0, 1'b0);
        step();
        chk("t3_count3", count, 3);
        drive(2, 32'h1c00010c, 1'b1, 1'b0);
        step();
        chk("t3_count4", count, 4);
        chk("t3_pc1_adv", out_pc1, 32'h1c000104);
        drive(0, 32'h0, 1'b0, 1'b1);
        step();
        chk("t3_nopop_count", count, 4);
        chk("t3_nopop_pc1", out_pc1, 32'h1c000104);
        drive(0, 32'h0, 1'b1, 1'b1);
        step();
        chk("t3_pop2_count", count, 2);
        chk("t3_pop2_pc1", out_pc1, 32'h1c00010c);
        chk("t3_pop2_pc2", out_pc2, 32'h1c000110);

        // flush at count=5 with a push pending
        drive(1, 32'h1c000114, 1'b0, 1'b0);
        step();
        drive(2, 32'h1c000118, 1'b0, 1'b0);
        step();
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t4_count5", count, 5);
        chk("t4_pause5", pause_req, 1);
        flush = 1'b1;
        drive(1, 32'h1c000120, 1'b1, 1'b0);
        step();
        flush = 1'b0;
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t4_count", count, 0);
        chk("t4_valid1", out_valid1, 0);
        chk("t4_pause", pause_req, 0);
        chk("t4_ovf", ovf_err, 0);

        // exception entry
        drive(1, 32'h1c000002, 1'b0, 1'b0);
        push_excp1  = 1'b1;
        push_cause1 = EXCEPTION_ADEF;
        step();
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t5_excp1", out_excp1, 1);
        chk("t5_cause1", out_cause1, EXCEPTION_ADEF);
        chk("t5_pc1", out_pc1, 32'h1c000002);
        chk("t5_valid2", out_valid2, 0);
        drive(1, 32'h1c000008, 1'b0, 1'b0);
        step();
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t5_excp2", out_excp2, 0);
        chk("t5_pc2", out_pc2, 32'h1c000008);
        chk("t5_inst2", out_inst2, ~32'h1c000008);
        chk("t5_excp1_kept", out_excp1, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_count", count, 0);

        // stream 40 pairs with random decode back-pressure
        mcount = 0;
        sent   = 0;
        popped = 0;
        cyc    = 0;
        exp_pc = 32'h1c010000;
        while ((sent < 40 || mcount > 0) && cyc < 400) begin
            r1 = 1'($urandom_range(0, 3) != 0);
            r2 = 1'($urandom_range(0, 1));
            pv = (sent < 40) && ((8 - mcount) >= 4);
            drive(pv ? 2 : 0, 32'h1c010000 + 32'(sent * 8), r1, r2);
            chk("t6_valid1", out_valid1, 32'(mcount >= 1));
            chk("t6_pause", pause_req, 32'((8 - mcount) < 4));
            chk("t6_ovf", ovf_err, 0);
            p1 = (mcount >= 1) && r1;
            p2 = p1 && (mcount >= 2) && r2;
            if (p1) begin
                chk("t6_pc1", out_pc1, exp_pc);
                exp_pc = exp_pc + 32'd4;
                popped++;
            end
            if (p2) begin
                chk("t6_pc2", out_pc2, exp_pc);
                exp_pc = exp_pc + 32'd4;
                popped++;
            end
            mcount = mcount + (pv ? 2 : 0) - int'(p1) - int'(p2);
            if (pv) sent++;
            step();
            cyc++;
        end
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t6_budget", 32'(cyc < 400), 1);
        chk("t6_popped", popped, 80);
        chk("t6_count_end", count, 0);

        // reset mid-operation
        drive(2, 32'h1c020000, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 32'h0, 1'b0, 1'b0);
        chk("t7_rst_count", count, 0);
        chk("t7_rst_valid1", out_valid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
